wb_arb2: RTL and testbench
==========================

WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 SHALL have no parameters; all widths are fixed (adr 32, dat 32, sel 4).
REQ-002 clk_i  input  1  sole clock, all state on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 m0_adr_i / m1_adr_i  input  32  master N byte address.
REQ-005 m0_dat_i / m1_dat_i  input  32  master N write data.
REQ-006 m0_dat_o / m1_dat_o  output  32  read data to master N.
REQ-007 m0_sel_i / m1_sel_i  input  4  master N byte selects.
REQ-008 m0_stb_i, m0_cyc_i, m0_we_i / m1_stb_i, m1_cyc_i, m1_we_i  input  1 each  master N strobe, cycle, write enable.
REQ-009 m0_ack_o / m1_ack_o  output  1  acknowledge to master N.
REQ-010 s_adr_o, s_dat_o, s_sel_o  output  32/32/4  to shared slave (block RAM).
REQ-011 s_stb_o, s_cyc_o, s_we_o  output  1 each  to shared slave.
REQ-012 s_dat_i, s_ack_i  input  32/1  from shared slave.

Function
REQ-013 SHALL implement the FSM states IDLE, GNT0 and GNT1, held in a registered state.
REQ-014 In IDLE, the next state SHALL be GNT0 if m0_cyc_i, else GNT1 if m1_cyc_i, else IDLE (fixed priority; see REQ-026 for the round-robin variant).
REQ-015 In GNTn, the FSM SHALL stay while mn_cyc_i=1; when mn_cyc_i=0 it SHALL go to the other GNT state if that master's cyc is 1, else to IDLE (no idle bubble on handover).
REQ-016 A grant SHALL never be revoked while the granted master holds cyc; bursts and back-to-back cycles are therefore atomic.
REQ-017 Latency: for a request from IDLE, s_cyc_o SHALL be asserted 1 cycle after mn_cyc_i rises; on handover, the new master's signals SHALL appear the cycle after the old cyc falls.
REQ-018 In GNTn, s_adr_o, s_dat_o, s_sel_o and s_we_o SHALL equal master n's inputs combinationally, s_cyc_o SHALL equal mn_cyc_i, and s_stb_o SHALL equal mn_stb_i & mn_cyc_i.
REQ-019 In IDLE, all slave outputs SHALL be 0.
REQ-020 mn_ack_o SHALL equal s_ack_i & (state==GNTn) & mn_stb_i; the non-granted master's ack SHALL be 0.
REQ-021 m0_dat_o and m1_dat_o SHALL both carry s_dat_i; validity is qualified only by ack.
REQ-022 Simultaneous requests from IDLE: m0 SHALL win in fixed-priority mode.
REQ-023 A slave ack arriving while the state is IDLE SHALL be ignored.

Reset
REQ-024 When rst_i=1 at a clock edge, the state SHALL become IDLE, including mid-transfer; in the following cycle s_cyc_o=s_stb_o=s_we_o=0, s_adr_o/s_dat_o/s_sel_o=0, m0_ack_o=m1_ack_o=0, and the round-robin pointer (if present) SHALL select m0.
REQ-025 A master SHALL be granted after reset only if it re-presents cyc; no pre-reset request SHALL be remembered.

Configuration
REQ-026 With WB_ARB2_ROUND_ROBIN_EN defined: a 1-bit last-grant register SHALL be updated on each GNTn entry, and simultaneous requests at IDLE or handover SHALL go to the master not granted last. Without the macro, REQ-014 fixed priority (m0) SHALL apply and the register SHALL be absent.

Structure
REQ-027 The state encodings (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) SHALL reside in the shared package wb_arb_pkg, with a 2'd3 state decoding to IDLE.
REQ-028 The block SHALL be a single module with no sub-modules; the next-grant logic SHALL be one combinational process.

Verification
REQ-029 The bench SHALL cover: m0 alone, write 0xDEADBEEF to adr 0x10 with sel=0xF, then read -> s_cyc_o high 1 cycle after m0_cyc_i, m0_ack_o on slave ack, m1_ack_o always 0, read data 0xDEADBEEF.
REQ-030 The bench SHALL cover: m0 and m1 both raise cyc in the same cycle from IDLE -> fixed mode grants m0 first, then m1 with zero idle cycles; RR mode with last=m0 grants m1 first.
REQ-031 The bench SHALL cover: m1 holding a 4-beat burst at adr 0x0..0xC while m0 requests -> m1 is never preempted, and m0 is granted the cycle after m1_cyc_i falls.
REQ-032 The bench SHALL cover: rst_i pulsed for 1 cycle during a GNT1 transfer -> the next cycle has all slave outputs 0 and both acks 0; m1 is re-granted only after it re-asserts cyc.
REQ-033 The bench SHALL cover: a spurious s_ack_i=1 while IDLE -> m0_ack_o=m1_ack_o=0.
REQ-034 The bench SHALL cover: RR mode with both masters requesting continuously for 10 single cycles -> grants alternate m0, m1, m0, and so on.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encodings
// and the idle-time grant selection helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  // Grant choice from IDLE; prefer_m1 only matters when both masters request.
  function automatic state_e idle_pick(input logic cyc0, input logic cyc1,
                                       input logic prefer_m1);
    state_e pick;
    pick = ST_IDLE;
    if (cyc0 && cyc1) begin
      pick = prefer_m1 ? ST_GNT1 : ST_GNT0;
    end else if (cyc0) begin
      pick = ST_GNT0;
    end else if (cyc1) begin
      pick = ST_GNT1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter in front of one shared slave; grants are held for
// the whole cyc. Define WB_ARB2_ROUND_ROBIN_EN for round-robin on contention.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no grant, slave outputs driven to 0 (2'd3 alias)
// GNT0    | master 0 owns the slave until m0_cyc_i drops
// GNT1    | master 1 owns the slave until m1_cyc_i drops
module wb_arb2
  import wb_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  state_e state_q, state_d;
  logic   prefer_m1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef WB_ARB2_ROUND_ROBIN_EN
  logic last_gnt_q, last_gnt_d;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_d == ST_GNT0 && state_q != ST_GNT0) begin
      last_gnt_d = 1'b0;
    end else if (state_d == ST_GNT1 && state_q != ST_GNT1) begin
      last_gnt_d = 1'b1;
    end
  end

  // Reset value marks m1 as last granted so m0 wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign prefer_m1 = ~last_gnt_q;
`else
  assign prefer_m1 = 1'b0;
`endif

  // Handover goes straight to the other master to avoid an idle bubble.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_GNT0: begin
        if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = idle_pick(m0_cyc_i, m1_cyc_i, prefer_m1);
    endcase
  end

  always_comb begin
    s_adr_o  = 32'h0;
    s_dat_o  = 32'h0;
    s_sel_o  = 4'h0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state_q)
      ST_GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & m0_cyc_i;
        m0_ack_o = s_ack_i & m0_stb_i;
      end
      ST_GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & m1_cyc_i;
        m1_ack_o = s_ack_i & m1_stb_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arb2.sv
// Bench for wb_arb2: directed master traffic against a small RAM slave model,
// with per-master expectation queues checked whenever an ack is presented.
module tb_wb_arb2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
  logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
  logic        m0_stb_i = 0, m0_cyc_i = 0, m0_we_i = 0;
  logic        m1_stb_i = 0, m1_cyc_i = 0, m1_we_i = 0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        m0_ack_o, m1_ack_o, s_stb_o, s_cyc_o, s_we_o, s_ack_i;

  wb_arb2 dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_we_i(m0_we_i), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk_i = ~clk_i;

`ifdef WB_ARB2_ROUND_ROBIN_EN
  localparam int T2_FIRST = 1;
`else
  localparam int T2_FIRST = 0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   ack_who[$];
  int   ack_at[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;

  logic        slv_ack = 1'b0;
  logic        slv_spur = 1'b0;
  logic [31:0] slv_rdat = 32'h0;
  logic [31:0] mem [16];

  assign s_ack_i = slv_ack | slv_spur;
  assign s_dat_i = slv_rdat;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  // Single-wait-state RAM: acks one cycle after a strobe, one ack per beat.
  always @(posedge clk_i) begin
    if (rst_i) begin
      slv_ack <= 1'b0;
    end else if (s_stb_o && s_cyc_o && !slv_ack) begin
      slv_ack  <= 1'b1;
      slv_rdat <= mem[s_adr_o[5:2]];
      if (s_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (s_sel_o[b]) mem[s_adr_o[5:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
        end
      end
    end else begin
      slv_ack <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input int m);
    exp_t e;
    if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
      n_checks++;
      n_err++;
      $display("FAIL sb_unexpected_ack: m%0d acked with nothing outstanding at cycle %0d", m, cyc_cnt);
    end else begin
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk($sformatf("m%0d_adr", m), 64'(s_adr_o), 64'(e.adr));
      chk($sformatf("m%0d_we", m), 64'(s_we_o), 64'(e.we));
      chk($sformatf("m%0d_sel", m), 64'(s_sel_o), 64'h0F);
      if (e.we) chk($sformatf("m%0d_wdat", m), 64'(s_dat_o), 64'(e.dat));
      else      chk($sformatf("m%0d_rdat", m), 64'((m == 0) ? m0_dat_o : m1_dat_o), 64'(e.dat));
    end
    ack_who.push_back(m);
    ack_at.push_back(cyc_cnt);
  endtask

  always @(negedge clk_i) begin
    if (m0_ack_o || m1_ack_o) begin
      chk("dual_ack", 64'(m0_ack_o & m1_ack_o), 64'd0);
      if (m0_ack_o) sb_check(0);
      if (m1_ack_o) sb_check(1);
    end
  end

  task automatic set_cyc(input int m, input logic v);
    if (m == 0) begin
      m0_cyc_i = v;
      if (!v) m0_stb_i = 1'b0;
    end else begin
      m1_cyc_i = v;
      if (!v) m1_stb_i = 1'b0;
    end
  endtask

  task automatic beat(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    exp_t e;
    int   n;
    logic got;
    e.we = we; e.adr = adr; e.dat = dat;
    if (m == 0) begin
      exp_q0.push_back(e);
      m0_stb_i = 1'b1; m0_we_i = we; m0_adr_i = adr; m0_sel_i = 4'hF;
      m0_dat_i = we ? dat : 32'h0;
    end else begin
      exp_q1.push_back(e);
      m1_stb_i = 1'b1; m1_we_i = we; m1_adr_i = adr; m1_sel_i = 4'hF;
      m1_dat_i = we ? dat : 32'h0;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk_i);
      n++;
      got = (m == 0) ? m0_ack_o : m1_ack_o;
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL beat_timeout: m%0d adr=0x%0h got no ack, wanted one within %0d cycles", m, adr, n);
    end
    @(posedge clk_i); #1;
    if (m == 0) m0_stb_i = 1'b0; else m1_stb_i = 1'b0;
  endtask

  task automatic clear_log();
    ack_who.delete();
    ack_at.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // reset state
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, m0_ack_o, m1_ack_o}), 64'd0);
    chk("rst_adr", 64'(s_adr_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // T1: m0 alone, write then read back
    clear_log();
    @(posedge clk_i); #1;
    set_cyc(0, 1'b1);
    @(negedge clk_i);
    chk("t1_lat_before", 64'(s_cyc_o), 64'd0);
    @(negedge clk_i);
    chk("t1_lat_after", 64'(s_cyc_o), 64'd1);
    beat(0, 1'b1, 32'h10, 32'hDEADBEEF);
    set_cyc(0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t1_idle_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'd0);
    chk("t1_idle_adr", 64'(s_adr_o), 64'd0);
    chk("t1_idle_dat", 64'(s_dat_o), 64'd0);
    @(posedge clk_i); #1;
    set_cyc(0, 1'b1);
    beat(0, 1'b0, 32'h10, 32'hDEADBEEF);
    set_cyc(0, 1'b0);
    chk("t1_ack_count", 64'(ack_who.size()), 64'd2);
    if (ack_who.size() == 2) chk("t1_only_m0", 64'(ack_who[0] + ack_who[1]), 64'd0);

    // T2: simultaneous requests from IDLE
    repeat (2) @(posedge clk_i);
    #1;
    clear_log();
    fork
      begin set_cyc(0, 1'b1); beat(0, 1'b1, 32'h20, 32'h0000_0A0A); set_cyc(0, 1'b0); end
      begin set_cyc(1, 1'b1); beat(1, 1'b1, 32'h24, 32'h0000_B1B1); set_cyc(1, 1'b0); end
    join
    chk("t2_count", 64'(ack_who.size()), 64'd2);
    if (ack_who.size() == 2) begin
      chk("t2_first", 64'(ack_who[0]), 64'(T2_FIRST));
      chk("t2_second", 64'(ack_who[1]), 64'(1 - T2_FIRST));
      chk("t2_handover_gap", 64'(ack_at[1] - ack_at[0]), 64'd3);
    end

    // T3: m1 burst is not preempted by m0
    repeat (2) @(posedge clk_i);
    #1;
    clear_log();
    fork
      begin
        set_cyc(1, 1'b1);
        for (int i = 0; i < 4; i++) beat(1, 1'b1, 32'(4 * i), 32'hC0DE_0000 + 32'(i));
        set_cyc(1, 1'b0);
      end
      begin
        repeat (2) @(posedge clk_i);
        #1;
        set_cyc(0, 1'b1);
        beat(0, 1'b0, 32'h10, 32'hDEADBEEF);
        set_cyc(0, 1'b0);
      end
    join
    chk("t3_count", 64'(ack_who.size()), 64'd5);
    if (ack_who.size() == 5) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t3_burst_%0d", i), 64'(ack_who[i]), 64'd1);
      chk("t3_m0_last", 64'(ack_who[4]), 64'd0);
      chk("t3_handover_gap", 64'(ack_at[4] - ack_at[3]), 64'd3);
    end

    // T4: reset pulse during a GNT1 transfer
    repeat (2) @(posedge clk_i);
    #1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_adr_i = 32'h30; m1_dat_i = 32'h5555_AAAA; m1_sel_i = 4'hF;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t4_granted", 64'(s_cyc_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t4_rst_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, m0_ack_o, m1_ack_o}), 64'd0);
    chk("t4_rst_adr", 64'(s_adr_o), 64'd0);
    chk("t4_rst_dat", 64'(s_dat_o), 64'd0);
    rst_i = 1'b0;
    set_cyc(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk($sformatf("t4_no_regrant_%0d", i), 64'(s_cyc_o), 64'd0);
    end
    @(posedge clk_i); #1;
    set_cyc(1, 1'b1);
    @(negedge clk_i);
    chk("t4_relat_before", 64'(s_cyc_o), 64'd0);
    @(negedge clk_i);
    chk("t4_relat_after", 64'(s_cyc_o), 64'd1);
    beat(1, 1'b0, 32'h8, 32'hC0DE_0002);
    set_cyc(1, 1'b0);

    // T5: spurious slave ack while IDLE, masters strobing without cyc
    repeat (2) @(posedge clk_i);
    #1;
    m0_stb_i = 1'b1; m0_adr_i = 32'h44;
    m1_stb_i = 1'b1; m1_adr_i = 32'h48;
    slv_spur = 1'b1;
    @(negedge clk_i);
    chk("t5_m0_ack", 64'(m0_ack_o), 64'd0);
    chk("t5_m1_ack", 64'(m1_ack_o), 64'd0);
    chk("t5_idle_adr", 64'(s_adr_o), 64'd0);
    @(posedge clk_i); #1;
    slv_spur = 1'b0;
    m0_stb_i = 1'b0;
    m1_stb_i = 1'b0;

    // T6: both masters request continuously, 10 single cycles
    repeat (2) @(posedge clk_i);
    #1;
    clear_log();
    fork
      for (int i = 0; i < 5; i++) begin
        set_cyc(0, 1'b1);
        beat(0, 1'b1, 32'h28, 32'hA000_0000 + 32'(i));
        set_cyc(0, 1'b0);
        @(posedge clk_i); #1;
      end
      for (int j = 0; j < 5; j++) begin
        set_cyc(1, 1'b1);
        beat(1, 1'b1, 32'h2C, 32'hB000_0000 + 32'(j));
        set_cyc(1, 1'b0);
        @(posedge clk_i); #1;
      end
    join
    chk("t6_count", 64'(ack_who.size()), 64'd10);
    if (ack_who.size() == 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("t6_alt_%0d", i), 64'(ack_who[i]), 64'(i % 2));
    end

    repeat (3) @(posedge clk_i);
    chk("sb_drain0", 64'(exp_q0.size()), 64'd0);
    chk("sb_drain1", 64'(exp_q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
